// File: rtl/snn_pkg.sv
// Shared widths, accumulator FSM encoding and saturating arithmetic for the SNN datapath.
package snn_pkg;

  localparam int unsigned DEF_TIME_W      = 8;
  localparam int unsigned DEF_WEIGHT_W    = 8;
  localparam int unsigned DEF_POTENTIAL_W = 32;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CLEAR      = 3'd1;
  localparam logic [2:0] S_WAIT_SPIKE = 3'd2;
  localparam logic [2:0] S_MAC        = 3'd3;
  localparam logic [2:0] S_TAIL       = 3'd4;
  localparam logic [2:0] S_ACK        = 3'd5;
  localparam logic [2:0] S_FLUSH      = 3'd6;
  localparam logic [2:0] S_DONE       = 3'd7;

  // Operands are sign-extended to 64 bits by the caller; the result is clamped to a
  // signed range of the given width, so the caller may truncate it to that width.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        width);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/snn_mac_sat.sv
// One-cycle MAC stage: registers the read potential, then adds weight*delta with saturation
// once the weight arrives from the ROM.
module snn_mac_sat import snn_pkg::*; #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned POTENTIAL_W = DEF_POTENTIAL_W,
  parameter int unsigned TIME_W      = DEF_TIME_W,
  parameter int unsigned WEIGHT_W    = DEF_WEIGHT_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   valid_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [POTENTIAL_W-1:0] acc_i,
  input  logic [WEIGHT_W-1:0]    weight_i,
  input  logic [TIME_W:0]        delta_i,
  output logic                   wr_en_o,
  output logic [ADDR_W-1:0]      wr_addr_o,
  output logic [POTENTIAL_W-1:0] sum_o
);

  localparam int unsigned ProdW = WEIGHT_W + TIME_W + 1;

  logic                   valid_q, valid_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [POTENTIAL_W-1:0] acc_q, acc_d;
  logic signed [ProdW-1:0] prod;

  always_comb begin
    valid_d = valid_i;
    addr_d  = addr_i;
    acc_d   = acc_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      acc_q   <= '0;
    end else if (en_i) begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
    end
  end

  // The weight belongs to the address issued last cycle, i.e. to acc_q.
  assign prod      = ProdW'($signed(weight_i)) * ProdW'($signed(delta_i));
  assign sum_o     = POTENTIAL_W'(sat_add(64'($signed(acc_q)), 64'(prod), POTENTIAL_W));
  assign wr_en_o   = valid_q;
  assign wr_addr_o = addr_q;

endmodule

// File: rtl/aer_spike_accumulator.sv
// AER receive/accumulate stage: V_j += W_ji * (t_ref - t_i) per spike, then streams the
// final potentials to the encoder and pulses layer done.
module aer_spike_accumulator import snn_pkg::*; #(
  parameter int unsigned MAX_NEURONS = 64,
  parameter int unsigned IN_ADDR_W   = 6,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned POTENTIAL_W = DEF_POTENTIAL_W,
  parameter int unsigned TIME_W      = DEF_TIME_W,
  parameter int unsigned WEIGHT_W    = DEF_WEIGHT_W
) (
  input  logic                        local_clk,
  input  logic                        rst_n,
  input  logic                        i_clk_en,
  input  logic                        i_layer_start,
  input  logic [ADDR_W:0]             i_out_count,
  input  logic [TIME_W-1:0]           i_t_ref,
  input  logic                        i_aer_req,
  output logic                        o_aer_ack,
  input  logic [TIME_W-1:0]           i_aer_time,
  input  logic [IN_ADDR_W-1:0]        i_aer_addr,
  input  logic                        i_input_done,
  output logic [IN_ADDR_W+ADDR_W-1:0] o_weight_rom_addr,
  input  logic [WEIGHT_W-1:0]         i_weight_data,
  output logic                        o_potential_wr_en,
  output logic [ADDR_W-1:0]           o_potential_wr_addr,
  output logic [POTENTIAL_W-1:0]      o_potential_wr_data,
  output logic                        o_layer_done,
  output logic                        o_busy
);

  logic [2:0]             state_q, state_d;
  logic [ADDR_W:0]        out_count_q, out_count_d;
  logic [TIME_W-1:0]      t_ref_q, t_ref_d;
  logic [TIME_W:0]        delta_q, delta_d;
  logic [IN_ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W:0]        cnt_q, cnt_d;
  logic                   done_pending_q, done_pending_d;
  logic                   ack_q, ack_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [POTENTIAL_W-1:0] wr_data_q, wr_data_d;
  logic                   layer_done_q, layer_done_d;

  logic [POTENTIAL_W-1:0] ram_q [MAX_NEURONS];

  logic [ADDR_W-1:0]      cnt_idx;
  logic [ADDR_W+1:0]      cnt_inc;
  logic                   cnt_last;
  logic                   cnt_live;
  logic [POTENTIAL_W-1:0] rd_data;
  logic                   clr_we;
  logic                   mac_issue;
  logic                   mac_we;
  logic [ADDR_W-1:0]      mac_addr;
  logic [POTENTIAL_W-1:0] mac_sum;

  // One counter serves clear, MAC and flush; "last" also covers an out_count of 0.
  assign cnt_idx  = cnt_q[ADDR_W-1:0];
  assign cnt_inc  = {1'b0, cnt_q} + (ADDR_W+2)'(1);
  assign cnt_last = cnt_inc >= {1'b0, out_count_q};
  assign cnt_live = cnt_q < out_count_q;
  assign rd_data  = ram_q[cnt_idx];

  always_comb begin
    state_d        = state_q;
    out_count_d    = out_count_q;
    t_ref_d        = t_ref_q;
    delta_d        = delta_q;
    src_d          = src_q;
    cnt_d          = cnt_q;
    done_pending_d = done_pending_q;
    ack_d          = ack_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    layer_done_d   = 1'b0;
    clr_we         = 1'b0;
    mac_issue      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_layer_start) begin
          out_count_d = i_out_count;
          t_ref_d     = i_t_ref;
          cnt_d       = '0;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        clr_we = cnt_live;
        if (cnt_last) state_d = S_WAIT_SPIKE;
        else          cnt_d   = cnt_inc[ADDR_W:0];
      end
      S_WAIT_SPIKE: begin
        if (i_aer_req) begin
          src_d   = i_aer_addr;
          delta_d = {t_ref_q[TIME_W-1], t_ref_q} - {i_aer_time[TIME_W-1], i_aer_time};
          cnt_d   = '0;
          state_d = (out_count_q == '0) ? S_TAIL : S_MAC;
        end else if (done_pending_q) begin
          cnt_d   = '0;
          state_d = S_FLUSH;
        end
      end
      S_MAC: begin
        mac_issue = 1'b1;
        if (cnt_last) state_d = S_TAIL;
        else          cnt_d   = cnt_inc[ADDR_W:0];
      end
      S_TAIL: begin
        ack_d   = 1'b1;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (!i_aer_req) begin
          ack_d   = 1'b0;
          state_d = S_WAIT_SPIKE;
        end
      end
      S_FLUSH: begin
        if (cnt_live) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_idx;
          wr_data_d = rd_data;
        end
        if (cnt_last) state_d = S_DONE;
        else          cnt_d   = cnt_inc[ADDR_W:0];
      end
      S_DONE: begin
        layer_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && i_input_done) done_pending_d = 1'b1;
    if (state_d == S_FLUSH && state_q != S_FLUSH) done_pending_d = 1'b0;
  end

  always_ff @(posedge local_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      out_count_q    <= '0;
      t_ref_q        <= '0;
      delta_q        <= '0;
      src_q          <= '0;
      cnt_q          <= '0;
      done_pending_q <= 1'b0;
      ack_q          <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      layer_done_q   <= 1'b0;
    end else if (i_clk_en) begin
      state_q        <= state_d;
      out_count_q    <= out_count_d;
      t_ref_q        <= t_ref_d;
      delta_q        <= delta_d;
      src_q          <= src_d;
      cnt_q          <= cnt_d;
      done_pending_q <= done_pending_d;
      ack_q          <= ack_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      layer_done_q   <= layer_done_d;
    end
  end

  // Potential RAM keeps its contents across reset; S_CLEAR initialises it per layer.
  always_ff @(posedge local_clk) begin
    if (i_clk_en) begin
      if (clr_we)      ram_q[cnt_idx]  <= '0;
      else if (mac_we) ram_q[mac_addr] <= mac_sum;
    end
  end

  snn_mac_sat #(
    .ADDR_W     (ADDR_W),
    .POTENTIAL_W(POTENTIAL_W),
    .TIME_W     (TIME_W),
    .WEIGHT_W   (WEIGHT_W)
  ) u_mac (
    .clk_i    (local_clk),
    .rst_ni   (rst_n),
    .en_i     (i_clk_en),
    .valid_i  (mac_issue),
    .addr_i   (cnt_idx),
    .acc_i    (rd_data),
    .weight_i (i_weight_data),
    .delta_i  (delta_q),
    .wr_en_o  (mac_we),
    .wr_addr_o(mac_addr),
    .sum_o    (mac_sum)
  );

  assign o_aer_ack           = ack_q;
  assign o_weight_rom_addr   = {src_q, cnt_idx};
  assign o_potential_wr_en   = wr_en_q;
  assign o_potential_wr_addr = wr_addr_q;
  assign o_potential_wr_data = wr_data_q;
  assign o_layer_done        = layer_done_q;
  assign o_busy              = state_q != S_IDLE;

endmodule

// File: tb/tb_aer_spike_accumulator.sv
// Directed bench for aer_spike_accumulator: a 32-bit and a 16-bit instance share stimulus,
// flush writes are checked against per-width expected-write queues.
module tb_aer_spike_accumulator;

  localparam int unsigned AW  = 6;
  localparam int unsigned IAW = 6;
  localparam int unsigned TW  = 8;
  localparam int unsigned WW  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clk_en = 1'b1;
  logic              layer_start = 1'b0;
  logic [AW:0]       out_count = '0;
  logic [TW-1:0]     t_ref = '0;
  logic              aer_req = 1'b0;
  logic [TW-1:0]     aer_time = '0;
  logic [IAW-1:0]    aer_addr = '0;
  logic              input_done = 1'b0;

  logic              ack32, ack16, busy32, busy16, wen32, wen16, ld32, ld16;
  logic [IAW+AW-1:0] ra32, ra16;
  logic [WW-1:0]     w32 = '0;
  logic [WW-1:0]     w16 = '0;
  logic [AW-1:0]     wa32, wa16;
  logic [31:0]       wd32;
  logic [15:0]       wd16;

  logic [WW-1:0]      rom [4096];
  logic signed [63:0] m32 [64];
  logic signed [63:0] m16 [64];

  typedef struct {
    logic [AW-1:0]      a;
    logic signed [63:0] d;
  } wr_t;
  wr_t q32[$];
  wr_t q16[$];
  wr_t e32, e16;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_wr32 = 0;
  int done32 = 0;
  int done16 = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clk_en) begin
      w32 <= rom[ra32];
      w16 <= rom[ra16];
    end
  end

  aer_spike_accumulator dut32 (
    .local_clk(clk), .rst_n(rst_n), .i_clk_en(clk_en), .i_layer_start(layer_start),
    .i_out_count(out_count), .i_t_ref(t_ref), .i_aer_req(aer_req), .o_aer_ack(ack32),
    .i_aer_time(aer_time), .i_aer_addr(aer_addr), .i_input_done(input_done),
    .o_weight_rom_addr(ra32), .i_weight_data(w32), .o_potential_wr_en(wen32),
    .o_potential_wr_addr(wa32), .o_potential_wr_data(wd32), .o_layer_done(ld32),
    .o_busy(busy32)
  );

  aer_spike_accumulator #(.POTENTIAL_W(16)) dut16 (
    .local_clk(clk), .rst_n(rst_n), .i_clk_en(clk_en), .i_layer_start(layer_start),
    .i_out_count(out_count), .i_t_ref(t_ref), .i_aer_req(aer_req), .o_aer_ack(ack16),
    .i_aer_time(aer_time), .i_aer_addr(aer_addr), .i_input_done(input_done),
    .o_weight_rom_addr(ra16), .i_weight_data(w16), .o_potential_wr_en(wen16),
    .o_potential_wr_addr(wa16), .o_potential_wr_data(wd16), .o_layer_done(ld16),
    .o_busy(busy16)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    if (v > hi) return hi;
    if (v < -hi - 64'sd1) return -hi - 64'sd1;
    return v;
  endfunction

  initial forever @(posedge clk) cyc++;

  // Scoreboard: every flush write pops and checks the oldest expected write.
  initial forever begin
    @(negedge clk);
    if (ld32) done32++;
    if (ld16) done16++;
    if (wen32) begin
      last_wr32 = cyc;
      if (q32.size() == 0) check("wr32_queue_depth", q32.size(), 1);
      else begin
        e32 = q32.pop_front();
        check("wr32_addr", wa32, e32.a);
        check("wr32_data", $signed(wd32), e32.d);
      end
    end
    if (wen16) begin
      if (q16.size() == 0) check("wr16_queue_depth", q16.size(), 1);
      else begin
        e16 = q16.pop_front();
        check("wr16_addr", wa16, e16.a);
        check("wr16_data", $signed(wd16), e16.d);
      end
    end
  end

  task automatic start_layer(input int n, input logic [TW-1:0] tref);
    out_count   = (AW+1)'(n);
    t_ref       = tref;
    layer_start = 1'b1;
    @(negedge clk);
    layer_start = 1'b0;
    for (int j = 0; j < 64; j++) begin
      m32[j] = 0;
      m16[j] = 0;
    end
    repeat (n + 2) @(negedge clk);
  endtask

  task automatic spike(input int src, input logic [TW-1:0] t, input int n, input int done_at,
                       input int stall_at);
    logic signed [63:0] delta;
    int  k;
    bit  seen;
    delta = $signed(t_ref) - $signed(t);
    for (int j = 0; j < n; j++) begin
      m32[j] = sat(m32[j] + $signed(rom[src*64+j]) * delta, 32);
      m16[j] = sat(m16[j] + $signed(rom[src*64+j]) * delta, 16);
    end
    aer_addr = IAW'(src);
    aer_time = t;
    aer_req  = 1'b1;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 300) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      input_done = (k == done_at);
      if (stall_at != 0 && k == stall_at) begin
        check("stall_rom_addr_before", ra32, (src * 64) + k - 1);
        clk_en = 1'b0;
        repeat (5) @(negedge clk);
        check("stall_rom_addr_after", ra32, (src * 64) + k - 1);
        check("stall_busy", busy32, 1);
        check("stall_ack", ack32, 0);
        clk_en = 1'b1;
      end
      if (ack32) seen = 1'b1;
    end
    input_done = 1'b0;
    if (!seen) begin
      check("ack_timeout", 0, 1);
      aer_req = 1'b0;
      return;
    end
    check("ack_latency", k, n + 2);
    check("ack16", ack16, 1);
    repeat (3) @(negedge clk);
    check("ack_hold", ack32, 1);
    aer_req = 1'b0;
    k = 0;
    while (ack32 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("ack_release", ack32, 0);
  endtask

  task automatic finish_layer(input int n, input bit send_done);
    int k;
    for (int j = 0; j < n; j++) begin
      q32.push_back('{a: AW'(j), d: m32[j]});
      q16.push_back('{a: AW'(j), d: m16[j]});
    end
    done32 = 0;
    done16 = 0;
    if (send_done) begin
      input_done = 1'b1;
      @(negedge clk);
      input_done = 1'b0;
    end
    k = 0;
    while (!ld32 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!ld32) check("layer_done_timeout", 0, 1);
    else if (n > 0) check("done_after_last_wr", cyc, last_wr32 + 1);
    repeat (4) @(negedge clk);
    check("done_pulses32", done32, 1);
    check("done_pulses16", done16, 1);
    check("q32_drained", q32.size(), 0);
    check("q16_drained", q16.size(), 0);
    check("idle_after_done", busy32, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", ack32, 0);
    check("rst_busy", busy32, 0);
    check("rst_wr_en", wen32, 0);
    check("rst_wr_data", $signed(wd32), 0);
    check("rst_layer_done", ld32, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single spike; a done pulse while idle must not leak into the layer.
    input_done = 1'b1;
    @(negedge clk);
    input_done = 1'b0;
    rom[5*64+0] = 8'd1;
    rom[5*64+1] = 8'hFE;
    rom[5*64+2] = 8'd3;
    rom[5*64+3] = 8'd0;
    start_layer(4, 8'd127);
    spike(5, 8'd27, 4, 0, 0);
    repeat (6) @(negedge clk);
    check("no_flush_without_done", busy32, 1);
    check("model_v1", m32[1], -200);
    finish_layer(4, 1'b1);

    // Saturation at 16 bits, positive and negative, one and two spikes.
    for (int s = 0; s < 2; s++) begin
      rom[1*64+0] = (s == 0) ? 8'd127 : 8'h80;
      for (int ns = 1; ns <= 2; ns++) begin
        start_layer(1, 8'd127);
        for (int r = 0; r < ns; r++) spike(1, 8'h80, 1, 0, 0);
        finish_layer(1, 1'b1);
      end
    end

    // Several spikes with random weights and times.
    for (int src = 10; src < 13; src++)
      for (int j = 0; j < 6; j++) rom[src*64+j] = WW'($urandom);
    start_layer(6, TW'($urandom));
    for (int src = 10; src < 13; src++) spike(src, TW'($urandom), 6, 0, 0);
    finish_layer(6, 1'b1);

    // Done while a spike is in MAC: flush only after req falls.
    for (int j = 0; j < 8; j++) rom[3*64+j] = WW'($urandom);
    start_layer(8, 8'd60);
    spike(3, 8'hEC, 8, 2, 0);
    finish_layer(8, 1'b0);

    // Same spike with a 5-cycle clock-enable stall in mid-MAC.
    start_layer(8, 8'd60);
    spike(3, 8'hEC, 8, 0, 3);
    finish_layer(8, 1'b1);

    // Reset mid-MAC, then a fresh layer.
    for (int j = 0; j < 6; j++) rom[9*64+j] = WW'($urandom);
    start_layer(6, 8'd100);
    aer_addr = 6'd9;
    aer_time = 8'd40;
    aer_req  = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack", ack32, 0);
    check("rst_mid_busy32", busy32, 0);
    check("rst_mid_busy16", busy16, 0);
    aer_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 6; j++) rom[9*64+j] = WW'($urandom);
    start_layer(6, 8'd100);
    spike(9, 8'd40, 6, 0, 0);
    finish_layer(6, 1'b1);

    // Empty layer.
    start_layer(0, 8'd10);
    spike(2, 8'd5, 0, 0, 0);
    finish_layer(0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
